icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter: LINE_CNT, default 16, number of one-word direct-mapped lines (power of two, 2..256).
REQ-002 SHALL have port: clk_in  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rdy_in  input  1  global ready; low freezes all state.
REQ-005 SHALL have port: flush_pipline  input  1  discard any in-flight fetch response.
REQ-006 SHALL have ports: fetch_req input 1, fetch_addr input 32, fetch_ready output 1, fetch_valid output 1, fetch_ins output 32.
REQ-007 SHALL have ports: try_start_insfetch_task output 1, insfetch_addr output 32, insfetch_task_accepted input 1, insfetch_task_done input 1, insfetch_ins_full input 32.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, DRAIN; fetch_ready = 1 only in IDLE.
REQ-009 SHALL accept a request when fetch_req & fetch_ready & rdy_in; fetch_addr[1:0] ignored; index = addr[log2(LINE_CNT)+1:2], tag = remaining upper bits.
REQ-010 SHALL, on hit at acceptance cycle N, assert fetch_valid for exactly one cycle at N+1 with stored word, staying in IDLE (back-to-back hits, one per cycle).
REQ-011 SHALL, on miss, go to REQ at N+1, driving try_start_insfetch_task=1 and insfetch_addr = {addr[31:2],2'b00}, both stable until insfetch_task_accepted.
REQ-012 SHALL leave REQ for WAIT on insfetch_task_accepted, deasserting try_start_insfetch_task next cycle.
REQ-013 SHALL, in WAIT on insfetch_task_done, write insfetch_ins_full, tag, valid=1 into the line and assert fetch_valid with that word next cycle, returning to IDLE.
REQ-014 SHALL treat accepted and done in the same cycle in REQ as REQ-013 (fill, respond, IDLE).
REQ-015 SHALL, on flush_pipline in IDLE, suppress the pending hit fetch_valid and ignore any fetch_req that cycle.
REQ-016 SHALL, on flush_pipline in REQ before acceptance, drop the request and return to IDLE next cycle.
REQ-017 SHALL, on flush_pipline in WAIT, enter DRAIN; DRAIN waits for insfetch_task_done, fills the line, never asserts fetch_valid, then IDLE.
REQ-018 SHALL treat flush coinciding with insfetch_task_done as fill-without-respond.
REQ-019 SHALL hold state, outputs and arrays unchanged while rdy_in=0 (handshake inputs ignored that cycle).

Reset
REQ-020 SHALL on rst_in low: state IDLE, all valid bits 0, fetch_valid 0, fetch_ins 0, try_start_insfetch_task 0, insfetch_addr 0; data/tag arrays not reset.
REQ-021 SHALL on reset mid-refill abandon the transaction with no fill; post-reset first fetch misses.

Configuration
REQ-022 SHALL with ICACHE_PERF_EN defined add outputs hit_count and miss_count (32-bit, wrap at 2^32), incremented once per accepted non-flushed hit/miss, reset to 0.
REQ-023 SHALL without ICACHE_PERF_EN omit those ports and counters entirely; function otherwise identical.

Structure
REQ-024 SHALL place state enum encoding (IDLE=0, REQ=1, WAIT=2, DRAIN=3) and XLEN=32 in shared package cpu_defs.
REQ-025 SHALL implement the tag/valid/data storage as one sub-module icache_array (combinational read, synchronous write port).

Verification
REQ-026 SHALL cover: reset, fetch 0x0000_0100 -> miss, try_start with insfetch_addr 0x100 until accepted, done with 0x0000_0013 -> fetch_valid, fetch_ins 0x13 one cycle later.
REQ-027 SHALL cover: repeat fetch 0x100 after fill -> fetch_valid at N+1, no try_start; fetch 0x103 -> same hit.
REQ-028 SHALL cover: LINE_CNT=16, fill 0x100, fetch 0x140 (same index) -> miss, refill; then 0x100 misses again.
REQ-029 SHALL cover: flush two cycles into WAIT -> DRAIN, done with 0xDEADBEEF -> no fetch_valid; next fetch of that address hits 0xDEADBEEF.
REQ-030 SHALL cover: rdy_in low for 3 cycles during REQ with accepted asserted -> no state change; progress resumes when rdy_in high.
REQ-031 SHALL cover: ICACHE_PERF_EN build, 1 miss + 3 hits -> miss_count 1, hit_count 3.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: data width and the instruction-cache FSM encoding.
// No ports; imported by icache_if, icache_array and icache.
package cpu_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Instruction-cache bus: the CPU fetch side plus the refill (insfetch) side.
// slave  : the cache (consumes fetch requests, issues refill tasks)
// master : the environment (CPU front end + memory refill engine)
interface icache_if;
  import cpu_defs::*;

  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_ins;

  logic            try_start_insfetch_task;
  logic [XLEN-1:0] insfetch_addr;
  logic            insfetch_task_accepted;
  logic            insfetch_task_done;
  logic [XLEN-1:0] insfetch_ins_full;

  modport slave (
    input  fetch_req, fetch_addr, insfetch_task_accepted, insfetch_task_done, insfetch_ins_full,
    output fetch_ready, fetch_valid, fetch_ins, try_start_insfetch_task, insfetch_addr
  );

  modport master (
    output fetch_req, fetch_addr, insfetch_task_accepted, insfetch_task_done, insfetch_ins_full,
    input  fetch_ready, fetch_valid, fetch_ins, try_start_insfetch_task, insfetch_addr
  );
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Combinational read port, synchronous write port. Only the valid bits are
// reset; tags and data come up undefined and are masked by valid.
// Ports: clk_in, rst_in (async active-low), i_rd_idx -> o_rd_valid/o_rd_tag/
// o_rd_data, i_we/i_wr_idx/i_wr_tag/i_wr_data (write sets valid).
module icache_array
  import cpu_defs::*;
#(
  parameter int LINE_CNT = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 26
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [XLEN-1:0]  o_rd_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_data
);

  logic [LINE_CNT-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [LINE_CNT];
  logic [XLEN-1:0]     r_data [LINE_CNT];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding refill.
// Ports: clk_in, rst_in (async active-low), rdy_in (global stall, low freezes
// everything), flush_pipline (discard in-flight response), bus (icache_if
// slave: fetch request/response and refill task handshake).
// Optional build macro ICACHE_PERF_EN adds hit_count/miss_count outputs.
//
// state | meaning
// IDLE  | ready for a fetch; hits answered next cycle
// REQ   | refill task offered, waiting for acceptance
// WAIT  | refill accepted, waiting for the word
// DRAIN | refill flushed, still owed a done; fill line but do not respond
module icache
  import cpu_defs::*;
#(
  parameter int LINE_CNT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINE_CNT);
  localparam int TAG_W = XLEN - IDX_W - 2;

  icache_state_e   r_state;
  logic            r_fetch_valid;
  logic [XLEN-1:0] r_fetch_ins;
  logic            r_try_start;
  logic [XLEN-1:0] r_insfetch_addr;

  logic [IDX_W-1:0] w_req_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [XLEN-1:0]  w_rd_data;
  logic             w_hit;
  logic             w_accept;
  logic             w_fill;
  logic             w_unused_lsb;

  assign w_req_idx    = bus.fetch_addr[IDX_W+1:2];
  assign w_req_tag    = bus.fetch_addr[XLEN-1:IDX_W+2];
  assign w_unused_lsb = ^bus.fetch_addr[1:0];

  assign bus.fetch_ready             = (r_state == IDLE);
  assign bus.fetch_valid             = r_fetch_valid;
  assign bus.fetch_ins               = r_fetch_ins;
  assign bus.try_start_insfetch_task = r_try_start;
  assign bus.insfetch_addr           = r_insfetch_addr;

  assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_accept = rdy_in && bus.fetch_req && (r_state == IDLE) && !flush_pipline;

  // The fill address is the held refill address, so a flush never loses
  // track of which line the outstanding done belongs to.
  assign w_fill = rdy_in && bus.insfetch_task_done &&
                  (((r_state == REQ) && bus.insfetch_task_accepted) ||
                   (r_state == WAIT) || (r_state == DRAIN));

  icache_array #(
    .LINE_CNT (LINE_CNT),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_rd_idx   (w_req_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_fill),
    .i_wr_idx   (r_insfetch_addr[IDX_W+1:2]),
    .i_wr_tag   (r_insfetch_addr[XLEN-1:IDX_W+2]),
    .i_wr_data  (bus.insfetch_ins_full)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state         <= IDLE;
      r_fetch_valid   <= 1'b0;
      r_fetch_ins     <= '0;
      r_try_start     <= 1'b0;
      r_insfetch_addr <= '0;
    end else if (rdy_in) begin
      r_fetch_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_fetch_valid <= 1'b1;
              r_fetch_ins   <= w_rd_data;
            end else begin
              r_state         <= REQ;
              r_try_start     <= 1'b1;
              r_insfetch_addr <= {bus.fetch_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        REQ: begin
          if (bus.insfetch_task_accepted) begin
            r_try_start <= 1'b0;
            if (bus.insfetch_task_done) begin
              r_state <= IDLE;
              if (!flush_pipline) begin
                r_fetch_valid <= 1'b1;
                r_fetch_ins   <= bus.insfetch_ins_full;
              end
            end else begin
              // Memory owns the task now, so a flush must still wait for done.
              r_state <= flush_pipline ? DRAIN : WAIT;
            end
          end else if (flush_pipline) begin
            r_try_start <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WAIT: begin
          if (bus.insfetch_task_done) begin
            r_state <= IDLE;
            if (!flush_pipline) begin
              r_fetch_valid <= 1'b1;
              r_fetch_ins   <= bus.insfetch_ins_full;
            end
          end else if (flush_pipline) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.insfetch_task_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (LINE_CNT = 16).
module tb_icache;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_pipline;
  int   n_chk  = 0;
  int   n_pass = 0;

  icache_if bus();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.LINE_CNT(16)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_pipline (flush_pipline),
    .bus           (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_in                     = 1'b0;
    rdy_in                     = 1'b1;
    flush_pipline              = 1'b0;
    bus.fetch_req              = 1'b0;
    bus.fetch_addr             = 32'h0;
    bus.insfetch_task_accepted = 1'b0;
    bus.insfetch_task_done     = 1'b0;
    bus.insfetch_ins_full      = 32'h0;
    tick(); tick(); tick();

    // reset state
    chk("rst_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_ins", bus.fetch_ins, 32'h0);
    chk("rst_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    chk("rst_iaddr", bus.insfetch_addr, 32'h0);
    rst_in = 1'b1;
    tick();

    // cold miss on 0x100, accepted after two cycles, done with 0x13
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
    tick();
    bus.fetch_req = 1'b0;
    chk("miss_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    chk("miss_iaddr", bus.insfetch_addr, 32'h100);
    chk("miss_ready", {31'd0, bus.fetch_ready}, 32'd0);
    tick();
    chk("req_hold_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    chk("req_hold_iaddr", bus.insfetch_addr, 32'h100);
    bus.insfetch_task_accepted = 1'b1;
    tick();
    bus.insfetch_task_accepted = 1'b0;
    chk("wait_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    chk("wait_valid", {31'd0, bus.fetch_valid}, 32'd0);
    bus.insfetch_task_done = 1'b1; bus.insfetch_ins_full = 32'h0000_0013;
    tick();
    bus.insfetch_task_done = 1'b0;
    chk("fill_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("fill_ins", bus.fetch_ins, 32'h13);
    chk("fill_ready", {31'd0, bus.fetch_ready}, 32'd1);
    tick();
    chk("fill_valid_1cyc", {31'd0, bus.fetch_valid}, 32'd0);

    // back-to-back hits, byte offset ignored
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
    tick();
    chk("hit_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("hit_ins", bus.fetch_ins, 32'h13);
    chk("hit_no_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    bus.fetch_addr = 32'h0000_0103;
    tick();
    bus.fetch_req = 1'b0;
    chk("hit103_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("hit103_ins", bus.fetch_ins, 32'h13);
    tick();
    chk("hit_idle_valid", {31'd0, bus.fetch_valid}, 32'd0);

    // conflict: 0x140 shares index 0 with 0x100; accepted+done together
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0140;
    tick();
    bus.fetch_req = 1'b0;
    chk("conf_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    chk("conf_iaddr", bus.insfetch_addr, 32'h140);
    bus.insfetch_task_accepted = 1'b1; bus.insfetch_task_done = 1'b1;
    bus.insfetch_ins_full = 32'h0000_0022;
    tick();
    bus.insfetch_task_accepted = 1'b0; bus.insfetch_task_done = 1'b0;
    chk("conf_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("conf_ins", bus.fetch_ins, 32'h22);
    chk("conf_try_low", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
    tick();
    bus.fetch_req = 1'b0;
    chk("evict_miss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    chk("evict_valid", {31'd0, bus.fetch_valid}, 32'd0);
    bus.insfetch_task_accepted = 1'b1;
    tick();
    bus.insfetch_task_accepted = 1'b0;
    bus.insfetch_task_done = 1'b1; bus.insfetch_ins_full = 32'h0000_0013;
    tick();
    bus.insfetch_task_done = 1'b0;
    chk("refill_ins", bus.fetch_ins, 32'h13);

    // flush two cycles into WAIT -> DRAIN, silent fill of 0x204
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0204;
    tick();
    bus.fetch_req = 1'b0;
    bus.insfetch_task_accepted = 1'b1;
    tick();
    bus.insfetch_task_accepted = 1'b0;
    tick();
    tick();
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    chk("drain_ready", {31'd0, bus.fetch_ready}, 32'd0);
    tick();
    chk("drain_hold", {31'd0, bus.fetch_ready}, 32'd0);
    bus.insfetch_task_done = 1'b1; bus.insfetch_ins_full = 32'hDEAD_BEEF;
    tick();
    bus.insfetch_task_done = 1'b0;
    chk("drain_no_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("drain_to_idle", {31'd0, bus.fetch_ready}, 32'd1);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0204;
    tick();
    bus.fetch_req = 1'b0;
    chk("drain_hit_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("drain_hit_ins", bus.fetch_ins, 32'hDEAD_BEEF);

    // flush in IDLE: hit suppressed, miss ignored
    flush_pipline = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
    tick();
    chk("iflush_hit", {31'd0, bus.fetch_valid}, 32'd0);
    bus.fetch_addr = 32'h0000_0300;
    tick();
    chk("iflush_miss", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    chk("iflush_ready", {31'd0, bus.fetch_ready}, 32'd1);
    flush_pipline = 1'b0;

    // flush in REQ before acceptance drops the request
    tick();
    bus.fetch_req = 1'b0;
    chk("rflush_req", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    chk("rflush_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    chk("rflush_ready", {31'd0, bus.fetch_ready}, 32'd1);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0300;
    tick();
    bus.fetch_req = 1'b0;
    chk("rflush_nofill", {31'd0, bus.try_start_insfetch_task}, 32'd1);

    // rdy_in low for 3 cycles in REQ with accepted asserted
    rdy_in = 1'b0; bus.insfetch_task_accepted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_try", {31'd0, bus.try_start_insfetch_task}, 32'd1);
      chk("stall_ready", {31'd0, bus.fetch_ready}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    bus.insfetch_task_accepted = 1'b0;
    chk("stall_resume", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    bus.insfetch_task_done = 1'b1; bus.insfetch_ins_full = 32'h0000_0055;
    tick();
    bus.insfetch_task_done = 1'b0;
    chk("stall_fill_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("stall_fill_ins", bus.fetch_ins, 32'h55);

    // reset mid-refill: no fill, previously valid lines forgotten
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0400;
    tick();
    bus.fetch_req = 1'b0;
    bus.insfetch_task_accepted = 1'b1;
    tick();
    bus.insfetch_task_accepted = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("mrst_try", {31'd0, bus.try_start_insfetch_task}, 32'd0);
    chk("mrst_iaddr", bus.insfetch_addr, 32'h0);
    chk("mrst_ins", bus.fetch_ins, 32'h0);
    rst_in = 1'b1;
    bus.insfetch_task_done = 1'b1; bus.insfetch_ins_full = 32'h0000_0077;
    tick();
    bus.insfetch_task_done = 1'b0;
    chk("mrst_no_valid", {31'd0, bus.fetch_valid}, 32'd0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0204;
    tick();
    bus.fetch_req = 1'b0;
    chk("mrst_miss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;

    // fresh reset, then 1 miss + 3 hits
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
    tick();
    bus.fetch_req = 1'b0;
    chk("perf_miss", {31'd0, bus.try_start_insfetch_task}, 32'd1);
    bus.insfetch_task_accepted = 1'b1; bus.insfetch_task_done = 1'b1;
    bus.insfetch_ins_full = 32'h0000_0013;
    tick();
    bus.insfetch_task_accepted = 1'b0; bus.insfetch_task_done = 1'b0;
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("perf_hit", {31'd0, bus.fetch_valid}, 32'd1);
    end
    bus.fetch_req = 1'b0;
    tick();
    chk("perf_idle", {31'd0, bus.fetch_valid}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("miss_count", miss_count, 32'd1);
    chk("hit_count", hit_count, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
